// File: rtl/btn_reader_if.sv
// Button reader bundle: raw active-low pins in, debounced level and one-cycle event pulses out.
// "release" is a reserved word, so the release event is carried on release_pulse.
interface btn_reader_if #(parameter int N_BTN = 4);
  logic [N_BTN-1:0] btn_n;
  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] release_pulse;
  logic [N_BTN-1:0] long_press;
  logic             tick;

  modport master (
    input  btn_n,
    output level, press, release_pulse, long_press, tick
  );

  modport slave (
    output btn_n,
    input  level, press, release_pulse, long_press, tick
  );
endinterface

// File: rtl/btn_reader.sv
// Debounced push-button reader: sync, per-button debounce FSM, press/release/long-press events.
// Optional auto-repeat of press after a long press is enabled by defining BTN_AUTOREPEAT_EN.
module btn_reader #(
  parameter int N_BTN          = 4,
  parameter int TICK_DIV       = 27_000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int LONG_TICKS     = 1000,
  parameter int REPEAT_TICKS   = 200
) (
  input  logic          clock,
  input  logic          rst_n,
  btn_reader_if.master  bus
);

  localparam int PW  = $clog2(TICK_DIV);
  localparam int DBW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int HW  = $clog2(LONG_TICKS + 1);

  localparam logic [PW-1:0]  PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]  PRE_PEN   = PW'(TICK_DIV - 2);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_TICKS - 1);
  localparam logic [HW-1:0]  HOLD_MAX  = HW'(LONG_TICKS);
  localparam logic [HW-1:0]  HOLD_PEN  = HW'(LONG_TICKS - 1);

`ifdef BTN_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);
`endif

  if (TICK_DIV < 2 || DEBOUNCE_TICKS < 1 || LONG_TICKS < 1 || REPEAT_TICKS < 1) begin : g_param_check
    $error("btn_reader: illegal parameter value");
  end

  typedef enum logic [1:0] {RELEASED, PRESS_DB, PRESSED, REL_DB} state_t;

  logic [PW-1:0]    pre_cnt;
  logic             tick_q;
  logic [N_BTN-1:0] sync1, sync2;
  logic [N_BTN-1:0] s;

  state_t           state     [N_BTN];
  logic [DBW-1:0]   db_cnt    [N_BTN];
  logic [HW-1:0]    hold_cnt  [N_BTN];
  logic [N_BTN-1:0] long_done;
`ifdef BTN_AUTOREPEAT_EN
  logic [RW-1:0]    rep_cnt   [N_BTN];
`endif

  logic [N_BTN-1:0] level_q, press_q, rel_q, long_q;

  // tick_q is registered one cycle ahead so it is high exactly while pre_cnt == TICK_DIV-1
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      tick_q  <= 1'b0;
    end else begin
      pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PW'(1);
      tick_q  <= (pre_cnt == PRE_PEN);
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= bus.btn_n;
      sync2 <= sync1;
    end
  end

  assign s = ~sync2;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BTN; i++) begin
        state[i]    <= RELEASED;
        db_cnt[i]   <= '0;
        hold_cnt[i] <= '0;
`ifdef BTN_AUTOREPEAT_EN
        rep_cnt[i]  <= '0;
`endif
      end
      long_done <= '0;
      level_q   <= '0;
      press_q   <= '0;
      rel_q     <= '0;
      long_q    <= '0;
    end else begin
      press_q <= '0;
      rel_q   <= '0;
      long_q  <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        case (state[i])
          RELEASED: begin
            if (s[i]) begin
              state[i]  <= PRESS_DB;
              db_cnt[i] <= '0;
            end
          end
          PRESS_DB: begin
            if (!s[i]) begin
              state[i] <= RELEASED;
            end else if (tick_q) begin
              if (db_cnt[i] == DB_LAST) begin
                state[i]     <= PRESSED;
                level_q[i]   <= 1'b1;
                press_q[i]   <= 1'b1;
                hold_cnt[i]  <= '0;
                long_done[i] <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
                rep_cnt[i]   <= '0;
`endif
              end else begin
                db_cnt[i] <= db_cnt[i] + DBW'(1);
              end
            end
          end
          PRESSED: begin
            if (!s[i]) begin
              state[i]  <= REL_DB;
              db_cnt[i] <= '0;
            end else if (tick_q) begin
              // hold_cnt only advances until the long press fires, so it cannot pass LONG_TICKS
              if (!long_done[i]) begin
                if (hold_cnt[i] != HOLD_MAX) hold_cnt[i] <= hold_cnt[i] + HW'(1);
                if (hold_cnt[i] == HOLD_PEN) begin
                  long_q[i]    <= 1'b1;
                  long_done[i] <= 1'b1;
                end
              end
`ifdef BTN_AUTOREPEAT_EN
              else if (rep_cnt[i] == REP_LAST) begin
                press_q[i] <= 1'b1;
                rep_cnt[i] <= '0;
              end else begin
                rep_cnt[i] <= rep_cnt[i] + RW'(1);
              end
`endif
            end
          end
          REL_DB: begin
            if (s[i]) begin
              state[i] <= PRESSED;
            end else if (tick_q) begin
              if (db_cnt[i] == DB_LAST) begin
                state[i]   <= RELEASED;
                level_q[i] <= 1'b0;
                rel_q[i]   <= 1'b1;
              end else begin
                db_cnt[i] <= db_cnt[i] + DBW'(1);
              end
            end
          end
          default: state[i] <= RELEASED;
        endcase
      end
    end
  end

  assign bus.level         = level_q;
  assign bus.press         = press_q;
  assign bus.release_pulse = rel_q;
  assign bus.long_press    = long_q;
  assign bus.tick          = tick_q;

endmodule
